// File: rtl/cpu4_pkg.sv
// Shared constants for the 4-bit computer control sequencer.
// This file holds the opcode set, the T-state encoding and the control-word bit map.
package cpu4_pkg;

    typedef logic [2:0]  tstate_t;
    typedef logic [15:0] ctrl_word_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam tstate_t T0 = 3'd0;
    localparam tstate_t T1 = 3'd1;
    localparam tstate_t T2 = 3'd2;
    localparam tstate_t T3 = 3'd3;
    localparam tstate_t T4 = 3'd4;

    localparam int unsigned CTRL_HLT = 15;
    localparam int unsigned CTRL_MI  = 14;
    localparam int unsigned CTRL_RI  = 13;
    localparam int unsigned CTRL_RO  = 12;
    localparam int unsigned CTRL_IO  = 11;
    localparam int unsigned CTRL_II  = 10;
    localparam int unsigned CTRL_AI  = 9;
    localparam int unsigned CTRL_AO  = 8;
    localparam int unsigned CTRL_EO  = 7;
    localparam int unsigned CTRL_SU  = 6;
    localparam int unsigned CTRL_BI  = 5;
    localparam int unsigned CTRL_OI  = 4;
    localparam int unsigned CTRL_CE  = 3;
    localparam int unsigned CTRL_CO  = 2;
    localparam int unsigned CTRL_J   = 1;
    localparam int unsigned CTRL_FI  = 0;

    function automatic ctrl_word_t bit_mask(input int unsigned idx);
        return ctrl_word_t'(1) << idx;
    endfunction

    localparam ctrl_word_t FETCH_T0    = bit_mask(CTRL_CO) | bit_mask(CTRL_MI);
    localparam ctrl_word_t FETCH_T1    = bit_mask(CTRL_RO) | bit_mask(CTRL_II) | bit_mask(CTRL_CE);
    localparam ctrl_word_t CTRL_HALTED = bit_mask(CTRL_HLT);

endpackage

// File: rtl/cpu4_control_sequencer_if.sv
// Connection bundle between the control sequencer and the rest of the CPU.
// The sequencer takes the master side, and the datapath or a bench takes the slave side.
interface cpu4_control_sequencer_if;
    import cpu4_pkg::*;

    logic       step_en;
    logic       run;
    logic [3:0] opcode;
    logic       flag_c;
    logic       flag_z;
    ctrl_word_t ctrl_word;
    logic       commit;
    tstate_t    tstate;
    logic       halted;

    modport master (
        input  step_en, run, opcode, flag_c, flag_z,
        output ctrl_word, commit, tstate, halted
    );

    modport slave (
        output step_en, run, opcode, flag_c, flag_z,
        input  ctrl_word, commit, tstate, halted
    );

endinterface

// File: rtl/cpu4_microcode_rom.sv
// Combinational microcode: maps (tstate, opcode, flags) to the control word and
// the index of the instruction's final step.
module cpu4_microcode_rom
    import cpu4_pkg::*;
(
    input  tstate_t    tstate,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output ctrl_word_t ctrl_word,
    output tstate_t    last_step
);

    opcode_e op;
    assign op = opcode_e'(opcode);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        ctrl_word = '0;
        last_step = T1;

        case (op)
            OP_LDA, OP_STA:                         last_step = T3;
            OP_ADD, OP_SUB:                         last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT:                         last_step = T2;
            default:                                last_step = T1;
        endcase

        case (tstate)
            T0: ctrl_word = FETCH_T0;
            T1: ctrl_word = FETCH_T1;
            T2: begin
                case (op)
                    OP_LDA, OP_ADD,
                    OP_SUB, OP_STA: ctrl_word = bit_mask(CTRL_IO) | bit_mask(CTRL_MI);
                    OP_LDI:         ctrl_word = bit_mask(CTRL_IO) | bit_mask(CTRL_AI);
                    OP_JMP:         ctrl_word = bit_mask(CTRL_IO) | bit_mask(CTRL_J);
                    // Conditional jumps collapse to an empty step when not taken.
                    OP_JC:          ctrl_word = flag_c ? (bit_mask(CTRL_IO) | bit_mask(CTRL_J)) : '0;
                    OP_JZ:          ctrl_word = flag_z ? (bit_mask(CTRL_IO) | bit_mask(CTRL_J)) : '0;
                    OP_OUT:         ctrl_word = bit_mask(CTRL_AO) | bit_mask(CTRL_OI);
                    OP_HLT:         ctrl_word = CTRL_HALTED;
                    default:        ctrl_word = '0;
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA:         ctrl_word = bit_mask(CTRL_RO) | bit_mask(CTRL_AI);
                    OP_ADD, OP_SUB: ctrl_word = bit_mask(CTRL_RO) | bit_mask(CTRL_BI);
                    OP_STA:         ctrl_word = bit_mask(CTRL_AO) | bit_mask(CTRL_RI);
                    default:        ctrl_word = '0;
                endcase
            end
            T4: begin
                case (op)
                    OP_ADD:  ctrl_word = bit_mask(CTRL_EO) | bit_mask(CTRL_AI) | bit_mask(CTRL_FI);
                    OP_SUB:  ctrl_word = bit_mask(CTRL_EO) | bit_mask(CTRL_AI) | bit_mask(CTRL_FI)
                                       | bit_mask(CTRL_SU);
                    default: ctrl_word = '0;
                endcase
            end
            default: ctrl_word = '0;
        endcase
    end

endmodule

// File: rtl/cpu4_control_sequencer.sv
// T-state sequencer for the 4-bit computer. It holds the step counter and the halt latch,
// and it gates the commit strobe on which every datapath register loads.
module cpu4_control_sequencer
    import cpu4_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    cpu4_control_sequencer_if.master      bus
);

    tstate_t    tstate;
    logic       halted;
    logic       commit;
    ctrl_word_t rom_ctrl;
    tstate_t    last_step;

    cpu4_microcode_rom u_rom (
        .tstate    (tstate),
        .opcode    (bus.opcode),
        .flag_c    (bus.flag_c),
        .flag_z    (bus.flag_z),
        .ctrl_word (rom_ctrl),
        .last_step (last_step)
    );

    // rst_n is folded in so nothing downstream loads while reset is asserted.
    assign commit = bus.step_en & bus.run & ~halted & rst_n;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update on the same edge.
        if (!rst_n) begin
            tstate <= T0;
            halted <= 1'b0;
        end else if (commit) begin
            if (tstate == T2 && bus.opcode == OP_HLT) begin
                halted <= 1'b1;
            end else if (tstate == last_step) begin
                tstate <= T0;
            end else begin
                tstate <= tstate + 3'd1;
            end
        end
    end

    assign bus.ctrl_word = halted ? CTRL_HALTED : rom_ctrl;
    assign bus.commit    = commit;
    assign bus.tstate    = tstate;
    assign bus.halted    = halted;

endmodule

// File: tb/tb_cpu4_control_sequencer.sv
// Vector-driven bench for cpu4_control_sequencer. Expected outputs ride a queue from the
// driver to a negedge monitor that compares them against the DUT.
module tb_cpu4_control_sequencer;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        step_en;
        logic        run;
        logic [3:0]  opcode;
        logic        fc;
        logic        fz;
        logic [15:0] ctrl;
        logic [2:0]  t;
        logic        commit;
        logic        halted;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   driver_done = 1'b0;

    vec_t tbl[$];
    vec_t sb[$];

    cpu4_control_sequencer_if bus ();

    cpu4_control_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic r, input logic se, input logic rn,
                                input logic [3:0] op, input logic c, input logic z,
                                input logic [15:0] ctrl, input logic [2:0] t,
                                input logic cm, input logic h);
        vec_t v;
        v.name = name; v.rst_n = r; v.step_en = se; v.run = rn; v.opcode = op;
        v.fc = c; v.fz = z; v.ctrl = ctrl; v.t = t; v.commit = cm; v.halted = h;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%04h required=0x%04h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst_n       = v.rst_n;
        bus.step_en = v.step_en;
        bus.run     = v.run;
        bus.opcode  = v.opcode;
        bus.flag_c  = v.fc;
        bus.flag_z  = v.fz;
        sb.push_back(v);
    endtask

    // The fetch steps are common to every instruction and commit on a running tick.
    task automatic add_fetch(inout vec_t q[$], input string tag, input logic [3:0] op,
                             input logic c, input logic z);
        q.push_back(mk({tag, "_t0"}, 1, 1, 1, op, c, z, 16'h4004, 3'd0, 1, 0));
        q.push_back(mk({tag, "_t1"}, 1, 1, 1, op, c, z, 16'h1408, 3'd1, 1, 0));
    endtask

    // Monitor: compares each queued expectation at the falling edge.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".ctrl"},   bus.ctrl_word,          e.ctrl);
                check({e.name, ".tstate"}, 16'(bus.tstate),        16'(e.t));
                check({e.name, ".commit"}, 16'(bus.commit),        16'(e.commit));
                check({e.name, ".halted"}, 16'(bus.halted),        16'(e.halted));
            end
        end
    end

    initial begin
        vec_t hs[$];

        // Reset held with ticks present, then LDI released straight into fetch.
        tbl.push_back(mk("rst_a", 0, 1, 1, 4'h5, 0, 0, 16'h4004, 3'd0, 0, 0));
        tbl.push_back(mk("rst_b", 0, 1, 1, 4'h5, 0, 0, 16'h4004, 3'd0, 0, 0));
        add_fetch(tbl, "ldi", 4'h5, 0, 0);
        tbl.push_back(mk("ldi_t2", 1, 1, 1, 4'h5, 0, 0, 16'h0A00, 3'd2, 1, 0));
        add_fetch(tbl, "add", 4'h2, 0, 0);
        tbl.push_back(mk("add_t2", 1, 1, 1, 4'h2, 0, 0, 16'h4800, 3'd2, 1, 0));
        tbl.push_back(mk("add_t3", 1, 1, 1, 4'h2, 0, 0, 16'h1020, 3'd3, 1, 0));
        tbl.push_back(mk("add_t4", 1, 1, 1, 4'h2, 0, 0, 16'h0281, 3'd4, 1, 0));
        add_fetch(tbl, "sub", 4'h3, 0, 0);
        tbl.push_back(mk("sub_t2", 1, 1, 1, 4'h3, 0, 0, 16'h4800, 3'd2, 1, 0));
        tbl.push_back(mk("sub_t3", 1, 1, 1, 4'h3, 0, 0, 16'h1020, 3'd3, 1, 0));
        tbl.push_back(mk("sub_t4", 1, 1, 1, 4'h3, 0, 0, 16'h02C1, 3'd4, 1, 0));
        add_fetch(tbl, "jc0", 4'h7, 0, 1);
        tbl.push_back(mk("jc0_t2", 1, 1, 1, 4'h7, 0, 1, 16'h0000, 3'd2, 1, 0));
        add_fetch(tbl, "jc1", 4'h7, 1, 0);
        tbl.push_back(mk("jc1_t2", 1, 1, 1, 4'h7, 1, 0, 16'h0802, 3'd2, 1, 0));
        add_fetch(tbl, "jz0", 4'h8, 1, 0);
        tbl.push_back(mk("jz0_t2", 1, 1, 1, 4'h8, 1, 0, 16'h0000, 3'd2, 1, 0));
        add_fetch(tbl, "jz1", 4'h8, 0, 1);
        tbl.push_back(mk("jz1_t2", 1, 1, 1, 4'h8, 0, 1, 16'h0802, 3'd2, 1, 0));
        add_fetch(tbl, "lda", 4'h1, 0, 0);
        tbl.push_back(mk("lda_t2", 1, 1, 1, 4'h1, 0, 0, 16'h4800, 3'd2, 1, 0));
        tbl.push_back(mk("lda_t3", 1, 1, 1, 4'h1, 0, 0, 16'h1200, 3'd3, 1, 0));
        add_fetch(tbl, "sta", 4'h4, 0, 0);
        tbl.push_back(mk("sta_t2", 1, 1, 1, 4'h4, 0, 0, 16'h4800, 3'd2, 1, 0));
        tbl.push_back(mk("sta_t3", 1, 1, 1, 4'h4, 0, 0, 16'h2100, 3'd3, 1, 0));
        add_fetch(tbl, "out", 4'hE, 0, 0);
        tbl.push_back(mk("out_t2", 1, 1, 1, 4'hE, 0, 0, 16'h0110, 3'd2, 1, 0));
        add_fetch(tbl, "nopb", 4'hB, 0, 0);
        add_fetch(tbl, "nop0", 4'h0, 0, 0);
        add_fetch(tbl, "jmp", 4'h6, 0, 0);
        tbl.push_back(mk("jmp_t2", 1, 1, 1, 4'h6, 0, 0, 16'h0802, 3'd2, 1, 0));
        tbl.push_back(mk("no_tick", 1, 0, 1, 4'h6, 0, 0, 16'h4004, 3'd0, 0, 0));

        // Pause at ADD T3. Ticks seen while paused are dropped.
        add_fetch(hs, "padd", 4'h2, 0, 0);
        hs.push_back(mk("padd_t2", 1, 1, 1, 4'h2, 0, 0, 16'h4800, 3'd2, 1, 0));
        for (int i = 0; i < 4; i++)
            hs.push_back(mk("pause", 1, 1, 0, 4'h2, 0, 0, 16'h1020, 3'd3, 0, 0));
        hs.push_back(mk("resume_idle", 1, 0, 1, 4'h2, 0, 0, 16'h1020, 3'd3, 0, 0));
        hs.push_back(mk("resume_t3", 1, 1, 1, 4'h2, 0, 0, 16'h1020, 3'd3, 1, 0));
        hs.push_back(mk("resume_t4", 1, 1, 1, 4'h2, 0, 0, 16'h0281, 3'd4, 1, 0));
        // Reset abandons an instruction in progress.
        add_fetch(hs, "radd", 4'h2, 0, 0);
        hs.push_back(mk("radd_t2rst", 0, 1, 1, 4'h2, 0, 0, 16'h4800, 3'd2, 0, 0));
        hs.push_back(mk("radd_after", 1, 0, 1, 4'h2, 0, 0, 16'h4004, 3'd0, 0, 0));
        // HLT latches and then ignores ticks until reset.
        add_fetch(hs, "hlt", 4'hF, 0, 0);
        hs.push_back(mk("hlt_t2", 1, 1, 1, 4'hF, 0, 0, 16'h8000, 3'd2, 1, 0));
        for (int i = 0; i < 10; i++)
            hs.push_back(mk("halted", 1, 1, 1, 4'hF, 0, 0, 16'h8000, 3'd2, 0, 1));
        hs.push_back(mk("hlt_rst", 0, 1, 1, 4'hF, 0, 0, 16'h8000, 3'd2, 0, 1));
        hs.push_back(mk("post_t0", 1, 1, 1, 4'hF, 0, 0, 16'h4004, 3'd0, 1, 0));
        hs.push_back(mk("post_t1", 1, 1, 1, 4'hF, 0, 0, 16'h1408, 3'd1, 1, 0));

        rst_n       = 1'b0;
        bus.step_en = 1'b1;
        bus.run     = 1'b1;
        bus.opcode  = 4'h5;
        bus.flag_c  = 1'b0;
        bus.flag_z  = 1'b0;
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        for (int i = 0; i < hs.size(); i++) apply(hs[i]);
        driver_done = 1'b1;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
